// File: rtl/sm3_pad_core_dw.sv
// SM3 message padder: INPT_DW-wide byte-enabled beats in, 32-bit big-endian padded words out.
// Optional byte-enable checking is compiled in with `define SM3_PAD_ERR_EN.
module sm3_pad_core_dw #(
  parameter int INPT_DW = 32,
  parameter int LEN_W   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INPT_DW-1:0]   msg_inpt_d_i,
  input  logic [INPT_DW/8-1:0] msg_inpt_vld_byte_i,
  input  logic                 msg_inpt_vld_i,
  input  logic                 msg_inpt_lst_i,
  output logic                 msg_inpt_rdy_o,
  input  logic                 pad_otpt_ena_i,
  output logic [31:0]          pad_otpt_d_o,
  output logic                 pad_otpt_vld_o,
  output logic                 pad_otpt_lst_o,
  output logic                 pad_otpt_err_o
);

  localparam int NB = INPT_DW / 8;
  localparam int NW = INPT_DW / 32;
  localparam int BW = $clog2(NB + 1);
  localparam int CW = $clog2(NW + 1);

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_PAD, S_ZERO, S_LENH, S_LENL} st_t;

  function automatic logic [BW-1:0] pop_bytes(input logic [NB-1:0] en);
    logic [BW-1:0] c;
    c = '0;
    for (int i = 0; i < NB; i++) c = c + BW'(en[i]);
    return c;
  endfunction

  // Keep the first nb bytes, place the 0x80 marker right after them, clear the rest.
  function automatic logic [INPT_DW-1:0] pad_beat(input logic [INPT_DW-1:0] d,
                                                  input logic [BW-1:0] nb);
    logic [INPT_DW-1:0] r;
    r = d;
    for (int b = 0; b < NB; b++) begin
      if (BW'(b) == nb)     r[INPT_DW-1-8*b -: 8] = 8'h80;
      else if (BW'(b) > nb) r[INPT_DW-1-8*b -: 8] = 8'h00;
    end
    return r;
  endfunction

  // Words of a beat worth emitting; a short last beat ends with its marker word.
  function automatic logic [CW-1:0] beat_words(input logic lst, input logic [BW-1:0] nb);
    if (!lst || nb == BW'(NB)) return CW'(NW);
    return CW'(nb >> 2) + CW'(1);
  endfunction

  st_t                st_q;
  logic [INPT_DW-1:0] hold_d_p0;
  logic [CW-1:0]      hold_cnt_p0;
  logic               hold_pad_p0;
  logic [31:0]        d_p1;
  logic               vld_p1;
  logic               lst_p1;
  logic [3:0]         wix_q;
  logic [LEN_W-1:0]   bit_len_q;
  logic [LEN_W-1:0]   len_q;
  logic               busy_q;
  logic [63:0]        len64;

  logic [BW-1:0]      beat_nb;
  logic [INPT_DW-1:0] beat_d;
  logic [CW-1:0]      beat_w;
  logic               beat_pad;
  logic [LEN_W-1:0]   beat_bits;
  logic               can_load;
  logic               acc;
  logic               ld_vld;
  logic               ld_lst;
  logic               ld_pad;
  logic               ld_hold;
  logic               ld_byp;
  logic               ld_gen;
  logic [31:0]        ld_d;

  assign len64    = 64'(len_q);
  assign can_load = !vld_p1 || pad_otpt_ena_i;
  assign msg_inpt_rdy_o = !busy_q &&
                          ((hold_cnt_p0 == '0) || (hold_cnt_p0 == CW'(1) && can_load));
  assign acc = msg_inpt_vld_i && msg_inpt_rdy_o;

  assign pad_otpt_d_o   = d_p1;
  assign pad_otpt_vld_o = vld_p1;
  assign pad_otpt_lst_o = lst_p1;

  // Stage p0 -> p1: pick the next word (holding reg, then bypassed beat, then padding FSM)
  always_comb begin
    beat_nb   = pop_bytes(msg_inpt_vld_byte_i);
    beat_d    = msg_inpt_lst_i ? pad_beat(msg_inpt_d_i, beat_nb) : msg_inpt_d_i;
    beat_w    = beat_words(msg_inpt_lst_i, beat_nb);
    beat_pad  = msg_inpt_lst_i && (beat_nb != BW'(NB));
    beat_bits = LEN_W'({beat_nb, 3'b000});
    ld_vld    = 1'b0;
    ld_lst    = 1'b0;
    ld_pad    = 1'b0;
    ld_hold   = 1'b0;
    ld_byp    = 1'b0;
    ld_gen    = 1'b0;
    ld_d      = '0;
    if (can_load) begin
      if (hold_cnt_p0 != '0) begin
        ld_vld  = 1'b1;
        ld_hold = 1'b1;
        ld_d    = hold_d_p0[INPT_DW-1 -: 32];
        ld_pad  = hold_pad_p0 && (hold_cnt_p0 == CW'(1));
      end else if (acc) begin
        ld_vld = 1'b1;
        ld_byp = 1'b1;
        ld_d   = beat_d[INPT_DW-1 -: 32];
        ld_pad = beat_pad && (beat_w == CW'(1));
      end else begin
        case (st_q)
          S_PAD: begin
            ld_vld = 1'b1;
            ld_gen = 1'b1;
            ld_pad = 1'b1;
            ld_d   = 32'h8000_0000;
          end
          S_ZERO: begin
            ld_vld = 1'b1;
            ld_gen = 1'b1;
          end
          S_LENH: begin
            ld_vld = 1'b1;
            ld_gen = 1'b1;
            ld_d   = len64[63:32];
          end
          S_LENL: begin
            ld_vld = 1'b1;
            ld_gen = 1'b1;
            ld_lst = 1'b1;
            ld_d   = len64[31:0];
          end
          default: ;
        endcase
      end
    end
  end

  // Stage p1: registered output word, word index, message bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= S_IDLE;
      hold_cnt_p0 <= '0;
      hold_pad_p0 <= 1'b0;
      d_p1        <= '0;
      vld_p1      <= 1'b0;
      lst_p1      <= 1'b0;
      wix_q       <= '0;
      bit_len_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      if (ld_vld) begin
        d_p1   <= ld_d;
        vld_p1 <= 1'b1;
        lst_p1 <= ld_lst;
        wix_q  <= wix_q + 4'd1;
      end else if (pad_otpt_ena_i) begin
        vld_p1 <= 1'b0;
        lst_p1 <= 1'b0;
      end
      if (vld_p1 && lst_p1 && pad_otpt_ena_i) busy_q <= 1'b0;
      if (ld_hold) hold_cnt_p0 <= hold_cnt_p0 - CW'(1);
      if (acc) begin
        hold_cnt_p0 <= ld_byp ? beat_w - CW'(1) : beat_w;
        hold_pad_p0 <= beat_pad;
        if (msg_inpt_lst_i) begin
          bit_len_q <= '0;
          busy_q    <= 1'b1;
          st_q      <= beat_pad ? S_DATA : S_PAD;
        end else begin
          bit_len_q <= bit_len_q + beat_bits;
          st_q      <= S_DATA;
        end
      end
      // A marker word at index 14 or 15 leaves no room for the length: zeros spill into a new block
      if (ld_vld && ld_pad) begin
        st_q <= (wix_q == 4'd13) ? S_LENH : S_ZERO;
      end else if (ld_gen) begin
        case (st_q)
          S_ZERO:  if (wix_q == 4'd13) st_q <= S_LENH;
          S_LENH:  st_q <= S_LENL;
          S_LENL:  st_q <= S_IDLE;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ld_hold) hold_d_p0 <= hold_d_p0 << 32;
    if (acc)     hold_d_p0 <= ld_byp ? (beat_d << 32) : beat_d;
    if (acc && msg_inpt_lst_i) len_q <= bit_len_q + beat_bits;
  end

`ifdef SM3_PAD_ERR_EN
  function automatic logic en_contig(input logic [NB-1:0] en);
    logic seen_zero;
    logic ok;
    seen_zero = 1'b0;
    ok        = 1'b1;
    for (int i = NB - 1; i >= 0; i--) begin
      if (!en[i])         seen_zero = 1'b1;
      else if (seen_zero) ok = 1'b0;
    end
    return ok;
  endfunction

  logic err_p1;

  always_ff @(posedge clk) begin
    if (rst) err_p1 <= 1'b0;
    else     err_p1 <= acc && (!en_contig(msg_inpt_vld_byte_i) ||
                               (!msg_inpt_lst_i && msg_inpt_vld_byte_i != '1));
  end

  assign pad_otpt_err_o = err_p1;
`else
  assign pad_otpt_err_o = 1'b0;
`endif

endmodule
